// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared FSM encodings and sizing helper for the sequential multiplier
// Purpose: state encodings and a constant-evaluable clog2 used to size the bit counter.
// Ports: none (package).
package mul_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Smallest r with 2**r >= value; used at elaboration time only.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_seq_param_if.sv
// rtl/mul_seq_param_if.sv - request/result bundle between the controller and the MUL unit
// Purpose: groups the operand request and the result/status signals of mul_seq_param.
// Ports (master drives): start, is_signed, multiplicand, multiplier
//       (slave drives):  product, busy, finish
interface mul_seq_param_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 is_signed;
  logic [WIDTH-1:0]     multiplicand;
  logic [WIDTH-1:0]     multiplier;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;
  logic                 finish;

  modport master (
    output start, is_signed, multiplicand, multiplier,
    input  product, busy, finish
  );

  modport slave (
    input  start, is_signed, multiplicand, multiplier,
    output product, busy, finish
  );
endinterface

// File: rtl/mul_sign_fix.sv
// rtl/mul_sign_fix.sv - N-bit conditional two's-complement negate
// Purpose: dout = neg ? -din : din, modulo 2**N.
// Ports: din [N-1:0] in, neg in, dout [N-1:0] out.
module mul_sign_fix #(
  parameter int N = 32
) (
  input  logic [N-1:0] din,
  input  logic         neg,
  output logic [N-1:0] dout
);

  assign dout = neg ? (~din + N'(1)) : din;

endmodule

// File: rtl/mul_seq_param.sv
// rtl/mul_seq_param.sv - parametrised shift-add multiplier retiring one multiplier bit per clock
// Purpose: IDLE -> CALC (WIDTH cycles) -> DONE -> IDLE; signed mode via magnitude multiply and
//          final conditional negate.
// Ports: clk, rst (async active-low), bus (slave): start, is_signed, multiplicand, multiplier in;
//        product [2*WIDTH-1:0], busy, finish out.
module mul_seq_param
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  mul_seq_param_if.slave       bus
);

  localparam int             CW   = clog2(WIDTH + 1);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      count_q, count_d;
  logic               armed_q, armed_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   mplr_q, mplr_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               neg_in;
  logic [WIDTH:0]     addend;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] next_acc;
  logic [2*WIDTH-1:0] prod_fixed;

  // Magnitudes only in signed mode. -2**(W-1) negates to itself, which read as unsigned
  // W bits is exactly 2**(W-1), so the corner case needs no extra bit.
  mul_sign_fix #(.N(WIDTH)) u_fix_a (
    .din  (bus.multiplicand),
    .neg  (bus.is_signed & bus.multiplicand[WIDTH-1]),
    .dout (mag_a)
  );

  mul_sign_fix #(.N(WIDTH)) u_fix_b (
    .din  (bus.multiplier),
    .neg  (bus.is_signed & bus.multiplier[WIDTH-1]),
    .dout (mag_b)
  );

  assign neg_in = bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);

  // Add into the upper half with a carry bit, then shift {carry, acc_hi, mplr} right by one.
  assign addend   = mplr_q[0] ? {1'b0, mcand_q} : {(WIDTH + 1){1'b0}};
  assign sum      = {1'b0, acc_hi_q} + addend;
  assign next_acc = {sum, mplr_q[WIDTH-1:1]};

  // The result is registered on the CALC->DONE transition so product is valid on the
  // same edge that raises finish.
  mul_sign_fix #(.N(2 * WIDTH)) u_fix_p (
    .din  (next_acc),
    .neg  (neg_q),
    .dout (prod_fixed)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    armed_d   = armed_q;
    neg_d     = neg_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    mplr_d    = mplr_q;
    product_d = product_q;

    // A low start re-arms; a start held high never retriggers.
    if (!bus.start) armed_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && armed_q) begin
          mcand_d  = mag_a;
          mplr_d   = mag_b;
          neg_d    = neg_in;
          acc_hi_d = '0;
          count_d  = '0;
          armed_d  = 1'b0;
          state_d  = ST_CALC;
        end
      end
      ST_CALC: begin
        acc_hi_d = next_acc[2*WIDTH-1:WIDTH];
        mplr_d   = next_acc[WIDTH-1:0];
        count_d  = count_q + CW'(1);
        if (count_q == LAST) begin
          product_d = prod_fixed;
          state_d   = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      armed_q   <= 1'b1;
      neg_q     <= 1'b0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      mplr_q    <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      armed_q   <= armed_d;
      neg_q     <= neg_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      mplr_q    <= mplr_d;
      product_q <= product_d;
    end
  end

  assign bus.product = product_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.finish  = (state_q == ST_DONE);

endmodule
